// File: rtl/comp_share_arbiter.sv
// Shares one combinational integer comparator between the branch unit and the
// SLT/SLTU ALU path: one registered transaction in flight, valid/ready on both sides.

package comp_share_pkg;
   typedef enum logic [2:0] {
      OP_BEQ      = 3'd0,
      OP_BNE      = 3'd1,
      OP_BLT      = 3'd2,
      OP_BGE      = 3'd3,
      OP_BLTU     = 3'd4,
      OP_BGEU     = 3'd5,
      OP_BUNKNOWN = 3'd7
   } comp_select_e;
endpackage

module comp_share_arbiter
   import comp_share_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            br_req_valid_i,
   output logic            br_req_ready_o,
   input  logic [XLEN-1:0] br_op_a_i,
   input  logic [XLEN-1:0] br_op_b_i,
   input  comp_select_e    br_op_sel_i,
   output logic            br_rsp_valid_o,
   input  logic            br_rsp_ready_i,
   output logic            br_rsp_taken_o,
   input  logic            slt_req_valid_i,
   output logic            slt_req_ready_o,
   input  logic [XLEN-1:0] slt_op_a_i,
   input  logic [XLEN-1:0] slt_op_b_i,
   input  comp_select_e    slt_op_sel_i,
   output logic            slt_rsp_valid_o,
   input  logic            slt_rsp_ready_i,
   output logic            slt_rsp_result_o,
   output logic [XLEN-1:0] comp_port_a_o,
   output logic [XLEN-1:0] comp_port_b_o,
   output comp_select_e    comp_op_sel_o,
   input  logic            comp_i
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EVAL = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_BR   = 2'b01;
   localparam logic [1:0] OWN_SLT  = 2'b10;

   localparam logic GRANT_BR  = 1'b0;
   localparam logic GRANT_SLT = 1'b1;

   logic [1:0]      state_r;
   logic [1:0]      state_nxt_s;
   logic [1:0]      owner_r;
   logic            last_grant_r;
   logic [XLEN-1:0] op_a_r;
   logic [XLEN-1:0] op_b_r;
   comp_select_e    op_sel_r;
   logic            result_r;
   logic            br_grant_s;
   logic            slt_grant_s;
   logic            accept_s;
   logic            rsp_active_s;
   logic            rsp_done_s;

   // Round-robin: on a conflict the side that was not granted last time wins.
   function automatic logic br_wins_f(input logic br_v, input logic slt_v, input logic last_g);
      logic win;
      win = 1'b0;
      if (br_v && slt_v) begin
         win = (last_g == GRANT_SLT);
      end else begin
         win = br_v;
      end
      return win;
   endfunction

   // Unknown operations always return a cleared result, whatever the comparator says.
   function automatic logic mask_result_f(input comp_select_e sel, input logic raw);
      logic res;
      case (sel)
         OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: res = raw;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   // Request grant: offered only while idle and not flushing.
   always_comb begin
      br_grant_s  = 1'b0;
      slt_grant_s = 1'b0;
      if ((state_r == ST_IDLE) && !flush_i) begin
         br_grant_s  = br_wins_f(br_req_valid_i, slt_req_valid_i, last_grant_r);
         slt_grant_s = slt_req_valid_i && !br_grant_s;
      end else begin
         br_grant_s  = 1'b0;
         slt_grant_s = 1'b0;
      end
   end

   assign accept_s     = br_grant_s | slt_grant_s;
   assign rsp_active_s = (state_r == ST_RESP) && !flush_i;

   // Response handshake with whichever side owns the transaction.
   always_comb begin
      rsp_done_s = 1'b0;
      if (rsp_active_s) begin
         case (owner_r)
            OWN_BR:  rsp_done_s = br_rsp_ready_i;
            OWN_SLT: rsp_done_s = slt_rsp_ready_i;
            default: rsp_done_s = 1'b1;
         endcase
      end else begin
         rsp_done_s = 1'b0;
      end
   end

   // Next-state logic; a flush returns to idle from any busy state.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = ST_EVAL;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_EVAL: begin
            if (flush_i) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RESP;
            end
         end
         ST_RESP: begin
            if (flush_i || rsp_done_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RESP;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State, owner and grant history; a flush leaves the grant history alone.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r      <= ST_IDLE;
         owner_r      <= OWN_NONE;
         last_grant_r <= GRANT_SLT;
      end else begin
         state_r <= state_nxt_s;
         if (accept_s) begin
            owner_r      <= br_grant_s ? OWN_BR : OWN_SLT;
            last_grant_r <= br_grant_s ? GRANT_BR : GRANT_SLT;
         end else if (state_nxt_s == ST_IDLE) begin
            owner_r <= OWN_NONE;
         end
      end
   end

   // Operand capture on accept.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         op_a_r   <= {XLEN{1'b0}};
         op_b_r   <= {XLEN{1'b0}};
         op_sel_r <= OP_BUNKNOWN;
      end else if (accept_s) begin
         op_a_r   <= br_grant_s ? br_op_a_i   : slt_op_a_i;
         op_b_r   <= br_grant_s ? br_op_b_i   : slt_op_b_i;
         op_sel_r <= br_grant_s ? br_op_sel_i : slt_op_sel_i;
      end
   end

   // Comparator result sampled at the end of EVAL, dropped if flushed.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         result_r <= 1'b0;
      end else if (state_r == ST_EVAL) begin
         result_r <= flush_i ? 1'b0 : mask_result_f(op_sel_r, comp_i);
      end
   end

   assign br_req_ready_o   = br_grant_s;
   assign slt_req_ready_o  = slt_grant_s;
   assign br_rsp_valid_o   = rsp_active_s && (owner_r == OWN_BR);
   assign slt_rsp_valid_o  = rsp_active_s && (owner_r == OWN_SLT);
   assign br_rsp_taken_o   = br_rsp_valid_o && result_r;
   assign slt_rsp_result_o = slt_rsp_valid_o && result_r;

   assign comp_port_a_o = (state_r == ST_EVAL) ? op_a_r : {XLEN{1'b0}};
   assign comp_port_b_o = (state_r == ST_EVAL) ? op_b_r : {XLEN{1'b0}};
   assign comp_op_sel_o = (state_r == ST_EVAL) ? op_sel_r : OP_BUNKNOWN;

endmodule

// File: tb/tb_comp_share_arbiter.sv
// Self-checking bench for comp_share_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level reference model.

module tb_comp_share_arbiter;
   import comp_share_pkg::*;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   logic         flush_i;
   logic         br_req_valid_i, br_req_ready_o, br_rsp_valid_o, br_rsp_ready_i, br_rsp_taken_o;
   logic [31:0]  br_op_a_i, br_op_b_i;
   comp_select_e br_op_sel_i;
   logic         slt_req_valid_i, slt_req_ready_o, slt_rsp_valid_o, slt_rsp_ready_i, slt_rsp_result_o;
   logic [31:0]  slt_op_a_i, slt_op_b_i;
   comp_select_e slt_op_sel_i;
   logic [31:0]  comp_port_a_o, comp_port_b_o;
   comp_select_e comp_op_sel_o;
   logic         comp_i;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic         is_slt;
      comp_select_e op;
      logic [31:0]  a;
      logic [31:0]  b;
      logic         exp;
   } vec_t;

   vec_t vecs [12];

   comp_share_arbiter #(.XLEN(32)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .br_req_valid_i(br_req_valid_i), .br_req_ready_o(br_req_ready_o),
      .br_op_a_i(br_op_a_i), .br_op_b_i(br_op_b_i), .br_op_sel_i(br_op_sel_i),
      .br_rsp_valid_o(br_rsp_valid_o), .br_rsp_ready_i(br_rsp_ready_i), .br_rsp_taken_o(br_rsp_taken_o),
      .slt_req_valid_i(slt_req_valid_i), .slt_req_ready_o(slt_req_ready_o),
      .slt_op_a_i(slt_op_a_i), .slt_op_b_i(slt_op_b_i), .slt_op_sel_i(slt_op_sel_i),
      .slt_rsp_valid_o(slt_rsp_valid_o), .slt_rsp_ready_i(slt_rsp_ready_i), .slt_rsp_result_o(slt_rsp_result_o),
      .comp_port_a_o(comp_port_a_o), .comp_port_b_o(comp_port_b_o), .comp_op_sel_o(comp_op_sel_o),
      .comp_i(comp_i)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic ref_cmp(input comp_select_e op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         OP_BEQ:  return (a == b);
         OP_BNE:  return (a != b);
         OP_BLT:  return ($signed(a) < $signed(b));
         OP_BGE:  return ($signed(a) >= $signed(b));
         OP_BLTU: return (a < b);
         OP_BGEU: return (a >= b);
         default: return 1'b0;
      endcase
   endfunction

   // Comparator stand-in; answers 1 for unknown ops so the arbiter must mask it.
   assign comp_i = (comp_op_sel_o == OP_BUNKNOWN) ? 1'b1 : ref_cmp(comp_op_sel_o, comp_port_a_o, comp_port_b_o);

   function automatic comp_select_e pick_op(input int unsigned k);
      case (k)
         0: return OP_BEQ;
         1: return OP_BNE;
         2: return OP_BLT;
         3: return OP_BGE;
         4: return OP_BLTU;
         5: return OP_BGEU;
         default: return OP_BUNKNOWN;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      flush_i = 1'b0;
      br_req_valid_i = 1'b0; br_op_a_i = 32'd0; br_op_b_i = 32'd0; br_op_sel_i = OP_BEQ; br_rsp_ready_i = 1'b0;
      slt_req_valid_i = 1'b0; slt_op_a_i = 32'd0; slt_op_b_i = 32'd0; slt_op_sel_i = OP_BLT; slt_rsp_ready_i = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_br_req_ready"}, br_req_ready_o, 1'b0);
      chk({tag, "_slt_req_ready"}, slt_req_ready_o, 1'b0);
      chk({tag, "_br_rsp_valid"}, br_rsp_valid_o, 1'b0);
      chk({tag, "_br_taken"}, br_rsp_taken_o, 1'b0);
      chk({tag, "_slt_rsp_valid"}, slt_rsp_valid_o, 1'b0);
      chk({tag, "_slt_result"}, slt_rsp_result_o, 1'b0);
      chk({tag, "_comp_a"}, comp_port_a_o, 32'd0);
      chk({tag, "_comp_b"}, comp_port_b_o, 32'd0);
      chk({tag, "_comp_sel"}, comp_op_sel_o, OP_BUNKNOWN);
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_ni = 1'b0;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
   endtask

   // Single-requester transaction from the vector table; operands scrambled after accept.
   task automatic run_vec(input vec_t v);
      if (v.is_slt) begin
         slt_req_valid_i = 1'b1; slt_op_a_i = v.a; slt_op_b_i = v.b; slt_op_sel_i = v.op;
      end else begin
         br_req_valid_i = 1'b1; br_op_a_i = v.a; br_op_b_i = v.b; br_op_sel_i = v.op;
      end
      #1;
      chk("vec_req_ready", v.is_slt ? slt_req_ready_o : br_req_ready_o, 1'b1);
      @(posedge clk_i); #1;
      br_req_valid_i = 1'b0; slt_req_valid_i = 1'b0;
      br_op_a_i = ~v.a; slt_op_a_i = ~v.a; br_op_b_i = ~v.b; slt_op_b_i = ~v.b;
      #1;
      chk("vec_eval_sel", comp_op_sel_o, v.op);
      chk("vec_eval_a", comp_port_a_o, v.a);
      chk("vec_eval_b", comp_port_b_o, v.b);
      chk("vec_eval_no_rsp", {br_rsp_valid_o, slt_rsp_valid_o}, 2'b00);
      @(posedge clk_i); #1;
      br_rsp_ready_i = 1'b1; slt_rsp_ready_i = 1'b1;
      #1;
      chk("vec_rsp_valid", {br_rsp_valid_o, slt_rsp_valid_o}, v.is_slt ? 2'b01 : 2'b10);
      chk("vec_rsp_result", v.is_slt ? slt_rsp_result_o : br_rsp_taken_o, v.exp);
      chk("vec_rsp_comp_sel", comp_op_sel_o, OP_BUNKNOWN);
      @(posedge clk_i); #1;
      br_rsp_ready_i = 1'b0; slt_rsp_ready_i = 1'b0;
      #1;
      chk("vec_idle_no_rsp", {br_rsp_valid_o, slt_rsp_valid_o}, 2'b00);
   endtask

   // Randomized traffic checked against a busy/owner/grant-history scoreboard.
   task automatic run_random(input int n);
      logic        busy = 1'b0;
      logic        own_br = 1'b0;
      logic        last_slt = 1'b1;
      int          acc_cyc = 0;
      logic        exp_res = 1'b0;
      comp_select_e exp_op = OP_BUNKNOWN;
      logic [31:0] exp_a = 32'd0, exp_b = 32'd0;
      logic        want_br, want_slt, rsp_now, in_eval;
      for (int c = 0; c < n; c++) begin
         if (!br_req_valid_i && ($urandom_range(0, 2) != 0)) begin
            br_req_valid_i = 1'b1;
            br_op_sel_i = pick_op($urandom_range(0, 6));
            br_op_a_i = $urandom;
            br_op_b_i = ($urandom_range(0, 2) == 0) ? br_op_a_i : $urandom;
         end
         if (!slt_req_valid_i && ($urandom_range(0, 2) != 0)) begin
            slt_req_valid_i = 1'b1;
            slt_op_sel_i = ($urandom_range(0, 1) == 1) ? OP_BLT : OP_BLTU;
            slt_op_a_i = $urandom;
            slt_op_b_i = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
         end
         flush_i = ($urandom_range(0, 15) == 0);
         br_rsp_ready_i = ($urandom_range(0, 1) == 1);
         slt_rsp_ready_i = ($urandom_range(0, 1) == 1);
         #1;
         want_br  = !busy && !flush_i && br_req_valid_i && (!slt_req_valid_i || last_slt);
         want_slt = !busy && !flush_i && slt_req_valid_i && !want_br;
         rsp_now  = busy && (c >= acc_cyc + 2) && !flush_i;
         in_eval  = busy && (c == acc_cyc + 1);
         chk("rnd_br_req_ready", br_req_ready_o, want_br);
         chk("rnd_slt_req_ready", slt_req_ready_o, want_slt);
         chk("rnd_br_rsp_valid", br_rsp_valid_o, rsp_now && own_br);
         chk("rnd_slt_rsp_valid", slt_rsp_valid_o, rsp_now && !own_br);
         if (rsp_now && own_br) chk("rnd_br_taken", br_rsp_taken_o, exp_res);
         if (rsp_now && !own_br) chk("rnd_slt_result", slt_rsp_result_o, exp_res);
         chk("rnd_comp_sel", comp_op_sel_o, in_eval ? exp_op : OP_BUNKNOWN);
         chk("rnd_comp_a", comp_port_a_o, in_eval ? exp_a : 32'd0);
         chk("rnd_comp_b", comp_port_b_o, in_eval ? exp_b : 32'd0);
         if (busy) begin
            if (flush_i || (rsp_now && (own_br ? br_rsp_ready_i : slt_rsp_ready_i))) busy = 1'b0;
         end else if (want_br || want_slt) begin
            busy = 1'b1; own_br = want_br; acc_cyc = c; last_slt = want_slt;
            exp_op  = want_br ? br_op_sel_i : slt_op_sel_i;
            exp_a   = want_br ? br_op_a_i : slt_op_a_i;
            exp_b   = want_br ? br_op_b_i : slt_op_b_i;
            exp_res = ref_cmp(exp_op, exp_a, exp_b);
         end
         @(posedge clk_i); #1;
         if (want_br) br_req_valid_i = 1'b0;
         if (want_slt) slt_req_valid_i = 1'b0;
      end
      clear_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{1'b0, OP_BEQ,      32'd5,          32'd5,          1'b1};
      vecs[1]  = '{1'b0, OP_BNE,      32'd1,          32'd2,          1'b1};
      vecs[2]  = '{1'b0, OP_BNE,      32'd7,          32'd7,          1'b0};
      vecs[3]  = '{1'b1, OP_BLT,      32'hFFFF_FFFF,  32'd1,          1'b1};
      vecs[4]  = '{1'b1, OP_BLTU,     32'hFFFF_FFFF,  32'd1,          1'b0};
      vecs[5]  = '{1'b0, OP_BGE,      32'hFFFF_FFFF,  32'd1,          1'b0};
      vecs[6]  = '{1'b0, OP_BGEU,     32'hFFFF_FFFF,  32'd1,          1'b1};
      vecs[7]  = '{1'b1, OP_BLT,      32'h8000_0000,  32'h7FFF_FFFF,  1'b1};
      vecs[8]  = '{1'b1, OP_BLTU,     32'h8000_0000,  32'h7FFF_FFFF,  1'b0};
      vecs[9]  = '{1'b0, OP_BUNKNOWN, 32'd3,          32'd3,          1'b0};
      vecs[10] = '{1'b0, OP_BGE,      32'd5,          32'd5,          1'b1};
      vecs[11] = '{1'b1, OP_BLTU,     32'd0,          32'd0,          1'b0};

      clear_inputs();
      rst_ni = 1'b0;
      #2;
      check_all_zero("reset");
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      #1;
      check_all_zero("idle");

      for (int i = 0; i < 12; i++) run_vec(vecs[i]);

      // Conflict round-robin from reset: br, slt, br, slt.
      do_reset();
      br_req_valid_i = 1'b1; br_op_sel_i = OP_BEQ; br_op_a_i = 32'd3; br_op_b_i = 32'd3;
      slt_req_valid_i = 1'b1; slt_op_sel_i = OP_BLT; slt_op_a_i = 32'hFFFF_FFF0; slt_op_b_i = 32'd5;
      br_rsp_ready_i = 1'b1; slt_rsp_ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("rr_grant", {br_req_ready_o, slt_req_ready_o}, (k % 2 == 0) ? 2'b10 : 2'b01);
         @(posedge clk_i); #1;
         chk("rr_eval_ready", {br_req_ready_o, slt_req_ready_o}, 2'b00);
         @(posedge clk_i); #1;
         chk("rr_rsp_owner", {br_rsp_valid_o, slt_rsp_valid_o}, (k % 2 == 0) ? 2'b10 : 2'b01);
         chk("rr_rsp_value", (k % 2 == 0) ? br_rsp_taken_o : slt_rsp_result_o, 1'b1);
         @(posedge clk_i); #1;
      end
      clear_inputs();

      // Response backpressure for four cycles.
      br_req_valid_i = 1'b1; br_op_sel_i = OP_BGEU; br_op_a_i = 32'd10; br_op_b_i = 32'd3;
      #1;
      chk("bp_br_ready", br_req_ready_o, 1'b1);
      @(posedge clk_i); #1;
      br_req_valid_i = 1'b0;
      slt_req_valid_i = 1'b1; slt_op_sel_i = OP_BLT; slt_op_a_i = 32'hFFFF_FFF0; slt_op_b_i = 32'd5;
      @(posedge clk_i); #1;
      for (int i = 0; i < 4; i++) begin
         chk("bp_rsp_valid", br_rsp_valid_o, 1'b1);
         chk("bp_taken", br_rsp_taken_o, 1'b1);
         chk("bp_req_ready", {br_req_ready_o, slt_req_ready_o}, 2'b00);
         @(posedge clk_i); #1;
      end
      br_rsp_ready_i = 1'b1;
      #1;
      chk("bp_handshake_valid", br_rsp_valid_o, 1'b1);
      @(posedge clk_i); #1;
      br_rsp_ready_i = 1'b0;
      #1;
      chk("bp_slt_ready_after", slt_req_ready_o, 1'b1);
      chk("bp_br_rsp_gone", br_rsp_valid_o, 1'b0);
      slt_rsp_ready_i = 1'b1;
      @(posedge clk_i); #1;
      slt_req_valid_i = 1'b0;
      @(posedge clk_i); #1;
      chk("bp_slt_rsp", {slt_rsp_valid_o, slt_rsp_result_o}, 2'b11);
      @(posedge clk_i); #1;
      clear_inputs();

      // Flush during EVAL of a BNE, then flush in IDLE and in RESP.
      br_req_valid_i = 1'b1; br_op_sel_i = OP_BNE; br_op_a_i = 32'd1; br_op_b_i = 32'd2;
      br_rsp_ready_i = 1'b1;
      #1;
      chk("fl_br_ready", br_req_ready_o, 1'b1);
      @(posedge clk_i); #1;
      br_req_valid_i = 1'b0; flush_i = 1'b1;
      #1;
      chk("fl_eval_no_rsp", br_rsp_valid_o, 1'b0);
      @(posedge clk_i); #1;
      flush_i = 1'b0;
      slt_req_valid_i = 1'b1; slt_op_sel_i = OP_BLT; slt_op_a_i = 32'hFFFF_FFFF; slt_op_b_i = 32'd1;
      #1;
      chk("fl_no_rsp_after", br_rsp_valid_o, 1'b0);
      chk("fl_next_accept", slt_req_ready_o, 1'b1);
      @(posedge clk_i); #1;
      slt_req_valid_i = 1'b0;
      #1;
      chk("fl_no_rsp_eval", br_rsp_valid_o, 1'b0);
      @(posedge clk_i); #1;
      slt_rsp_ready_i = 1'b1;
      #1;
      chk("fl_slt_rsp", {br_rsp_valid_o, slt_rsp_valid_o, slt_rsp_result_o}, 3'b011);
      @(posedge clk_i); #1;
      slt_rsp_ready_i = 1'b0;
      flush_i = 1'b1; br_req_valid_i = 1'b1; br_op_sel_i = OP_BEQ; br_op_a_i = 32'd9; br_op_b_i = 32'd9;
      #1;
      chk("fl_idle_ready", br_req_ready_o, 1'b0);
      @(posedge clk_i); #1;
      flush_i = 1'b0;
      #1;
      chk("fl_idle_release", br_req_ready_o, 1'b1);
      @(posedge clk_i); #1;
      br_req_valid_i = 1'b0;
      @(posedge clk_i); #1;
      chk("fl_resp_before", br_rsp_valid_o, 1'b1);
      flush_i = 1'b1;
      #1;
      chk("fl_resp_gated", br_rsp_valid_o, 1'b0);
      @(posedge clk_i); #1;
      flush_i = 1'b0;
      #1;
      chk("fl_resp_dropped", br_rsp_valid_o, 1'b0);
      clear_inputs();

      // Asynchronous reset in RESP, then the first conflict goes to br.
      @(posedge clk_i); #1;
      br_req_valid_i = 1'b1; br_op_sel_i = OP_BEQ; br_op_a_i = 32'd4; br_op_b_i = 32'd4;
      #1;
      chk("ar_br_ready", br_req_ready_o, 1'b1);
      @(posedge clk_i); #1;
      br_req_valid_i = 1'b0;
      @(posedge clk_i); #1;
      chk("ar_rsp_before", {br_rsp_valid_o, br_rsp_taken_o}, 2'b11);
      rst_ni = 1'b0;
      #1;
      check_all_zero("async_reset");
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      br_req_valid_i = 1'b1; slt_req_valid_i = 1'b1;
      #1;
      chk("ar_first_conflict", {br_req_ready_o, slt_req_ready_o}, 2'b10);
      chk("ar_no_stale_rsp", br_rsp_valid_o, 1'b0);
      clear_inputs();

      do_reset();
      run_random(800);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
